// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared FIFO helpers: Gray <-> binary conversion, a one-bit counter for the
// Gray checker, and the default pointer width.
// The helpers work on a 32-bit container. Callers zero-extend narrower
// pointers and truncate the result. Leading zeros do not change either
// conversion.
package fifo_pkg;

  localparam int DEFAULT_PTR_WIDTH = 3;

  // Gray to binary: the MSB is copied, and each lower bit is the XOR of the
  // binary bit above it with the Gray bit in the same position.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned count_ones(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n = n + int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// sync_ff_chain
// A multi-flop synchronizer that carries a vector into the clk domain.
// The output q equals d as sampled STAGES rising edges of clk earlier.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset; clears every stage
//   d     - input vector. It may be asynchronous to clk.
//   q     - synchronized vector, taken from the last stage
// Parameters: WIDTH is the vector width. STAGES is the flop count and is
// meaningful from 2 to 4.
module sync_ff_chain #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [STAGES];

  // Only stage 0 sees the asynchronous input. Every later stage takes its
  // value from the stage before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_reg[i] <= '0;
      end
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/wr_rptr_sync_decoder.sv
// wr_rptr_sync_decoder
// Write-side handling of the read pointer for an asynchronous FIFO.
// The block does the following:
//   - synchronizes the Gray read pointer into wrclk;
//   - decodes that pointer to binary;
//   - computes the occupancy seen from the write side;
//   - raises the full and almost-full flags;
//   - keeps sticky overflow and Gray-sequence error flags.
// Optional feature: define WR_GRAY_CHECK_EN to build the Gray single-bit-change
// checker. Without it, gray_err is tied to 0.
// Ports:
//   wrclk, wrst_n  - write clock and asynchronous active-low reset
//   g_rptr         - Gray read pointer from the read domain (asynchronous)
//   b_wptr         - binary write pointer (wrclk domain)
//   wr_en          - write attempt this cycle
//   clr_err        - clears the sticky error flags
//   g_rptr_sync    - synchronized Gray read pointer
//   b_rptr_sync    - binary decode of g_rptr_sync, one cycle later
//   wr_level       - (b_wptr - b_rptr_sync) modulo 2**(PTR_WIDTH+1), registered
//   fifo_full      - registered; high when the level equals the FIFO depth
//   almost_full    - registered; high when the level is at least AFULL_THRESH
//   overflow_err   - sticky; set by a write attempt while full
//   gray_err       - sticky; set by a multi-bit step of g_rptr_sync
module wr_rptr_sync_decoder
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH    = DEFAULT_PTR_WIDTH,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6
) (
  input  logic               wrclk,
  input  logic               wrst_n,
  input  logic [PTR_WIDTH:0] g_rptr,
  input  logic [PTR_WIDTH:0] b_wptr,
  input  logic               wr_en,
  input  logic               clr_err,
  output logic [PTR_WIDTH:0] g_rptr_sync,
  output logic [PTR_WIDTH:0] b_rptr_sync,
  output logic [PTR_WIDTH:0] wr_level,
  output logic               fifo_full,
  output logic               almost_full,
  output logic               overflow_err,
  output logic               gray_err
);

  localparam int PW = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] FULL_LVL  = {1'b1, {PTR_WIDTH{1'b0}}};
  localparam logic [PTR_WIDTH:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PTR_WIDTH:0] g_sync;
  logic [PTR_WIDTH:0] b_dec;
  logic [PTR_WIDTH:0] b_rptr_reg;
  logic [PTR_WIDTH:0] level_next;
  logic [PTR_WIDTH:0] level_reg;
  logic               full_reg;
  logic               afull_reg;
  logic               ovf_reg;
  logic               ovf_next;

  // g_rptr reaches only this chain. Everything below uses the synchronized copy.
  sync_ff_chain #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (wrclk),
    .rst_n (wrst_n),
    .d     (g_rptr),
    .q     (g_sync)
  );

  always_comb begin
    b_dec      = PW'(gray2bin(32'(g_sync)));
    // Pointer wrap is handled by the natural modulo of a PW-bit subtract.
    level_next = b_wptr - b_rptr_reg;
    ovf_next   = ovf_reg;
    if (wr_en && full_reg) begin
      ovf_next = 1'b1;          // setting the flag takes priority over clearing it
    end else if (clr_err) begin
      ovf_next = 1'b0;
    end
  end

  // fifo_full and almost_full come from the same next-level value as wr_level.
  // The three outputs therefore always agree with each other.
  always_ff @(posedge wrclk or negedge wrst_n) begin
    if (!wrst_n) begin
      b_rptr_reg <= '0;
      level_reg  <= '0;
      full_reg   <= 1'b0;
      afull_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      b_rptr_reg <= b_dec;
      level_reg  <= level_next;
      full_reg   <= (level_next == FULL_LVL);
      afull_reg  <= (level_next >= AFULL_LVL);
      ovf_reg    <= ovf_next;
    end
  end

`ifdef WR_GRAY_CHECK_EN
  logic [PTR_WIDTH:0] g_prev_reg;
  logic               gray_err_reg;
  logic               gray_multi;

  // A correctly synchronized Gray pointer changes by at most one bit per sample.
  assign gray_multi = (count_ones(32'(g_sync ^ g_prev_reg)) > 1);

  always_ff @(posedge wrclk or negedge wrst_n) begin
    if (!wrst_n) begin
      g_prev_reg   <= '0;
      gray_err_reg <= 1'b0;
    end else begin
      g_prev_reg <= g_sync;
      if (gray_multi) begin
        gray_err_reg <= 1'b1;
      end else if (clr_err) begin
        gray_err_reg <= 1'b0;
      end
    end
  end

  assign gray_err = gray_err_reg;
`else
  assign gray_err = 1'b0;
`endif

  assign g_rptr_sync  = g_sync;
  assign b_rptr_sync  = b_rptr_reg;
  assign wr_level     = level_reg;
  assign fifo_full    = full_reg;
  assign almost_full  = afull_reg;
  assign overflow_err = ovf_reg;

endmodule

// File: tb/tb_wr_rptr_sync_decoder.sv
module tb_wr_rptr_sync_decoder;

  localparam int PW = 3;
  localparam int S  = 2;
  localparam int AF = 6;
`ifdef WR_GRAY_CHECK_EN
  localparam bit GRAY_ON = 1'b1;
`else
  localparam bit GRAY_ON = 1'b0;
`endif

  logic       wrclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic [3:0] g_rptr = '0;
  logic [3:0] b_wptr = '0;
  logic       wr_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [3:0] g_rptr_sync, b_rptr_sync, wr_level;
  logic       fifo_full, almost_full, overflow_err, gray_err;

  int n_checks = 0;
  int n_fail   = 0;

  wr_rptr_sync_decoder #(
    .PTR_WIDTH    (PW),
    .SYNC_STAGES  (S),
    .AFULL_THRESH (AF)
  ) dut (
    .wrclk        (wrclk),
    .wrst_n       (wrst_n),
    .g_rptr       (g_rptr),
    .b_wptr       (b_wptr),
    .wr_en        (wr_en),
    .clr_err      (clr_err),
    .g_rptr_sync  (g_rptr_sync),
    .b_rptr_sync  (b_rptr_sync),
    .wr_level     (wr_level),
    .fifo_full    (fifo_full),
    .almost_full  (almost_full),
    .overflow_err (overflow_err),
    .gray_err     (gray_err)
  );

  always #5 wrclk = ~wrclk;

  // The reference model tracks what each output should be after every
  // active clock edge.
  logic [3:0] m_hist [S];
  logic [3:0] m_gs, m_prev, m_bs, m_lvl;
  logic       m_full, m_af, m_ovf, m_gerr;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [3:0] to_bin(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < S; i++) m_hist[i] = '0;
    m_gs = '0; m_prev = '0; m_bs = '0; m_lvl = '0;
    m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0; m_gerr = 1'b0;
  endfunction

  function automatic void model_step(input logic [3:0] g, input logic [3:0] w,
                                     input logic we, input logic clr);
    logic [3:0] lvl_n;
    m_gerr = GRAY_ON && (($countones(m_gs ^ m_prev) > 1) || (m_gerr && !clr));
    m_ovf  = (we && m_full) || (m_ovf && !clr);
    lvl_n  = w - m_bs;
    m_lvl  = lvl_n;
    m_full = (int'(lvl_n) == 2**PW);
    m_af   = (int'(lvl_n) >= AF);
    m_bs   = to_bin(m_gs);
    m_prev = m_gs;
    for (int i = S - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = g;
    m_gs = m_hist[S-1];
  endfunction

  function automatic void compare_model();
    check("g_rptr_sync", 32'(g_rptr_sync), 32'(m_gs));
    check("b_rptr_sync", 32'(b_rptr_sync), 32'(m_bs));
    check("wr_level", 32'(wr_level), 32'(m_lvl));
    check("fifo_full", 32'(fifo_full), 32'(m_full));
    check("almost_full", 32'(almost_full), 32'(m_af));
    check("overflow_err", 32'(overflow_err), 32'(m_ovf));
    check("gray_err", 32'(gray_err), 32'(m_gerr));
  endfunction

  function automatic void check_all_zero(input string tag);
    check({tag, "_gsync"}, 32'(g_rptr_sync), 0);
    check({tag, "_bsync"}, 32'(b_rptr_sync), 0);
    check({tag, "_level"}, 32'(wr_level), 0);
    check({tag, "_full"}, 32'(fifo_full), 0);
    check({tag, "_afull"}, 32'(almost_full), 0);
    check({tag, "_ovf"}, 32'(overflow_err), 0);
    check({tag, "_gerr"}, 32'(gray_err), 0);
  endfunction

  // One write-clock cycle: drive the inputs at the falling edge, step the
  // model at the rising edge, then compare 1 time unit later.
  task automatic cycle(input logic [3:0] g, input logic [3:0] w, input logic we, input logic clr);
    @(negedge wrclk);
    g_rptr = g; b_wptr = w; wr_en = we; clr_err = clr;
    @(posedge wrclk);
    model_step(g, w, we, clr);
    #1;
    compare_model();
  endtask

  // Assert reset between clock edges, check that it acts at once, then
  // release it just after a rising edge.
  task automatic do_reset(input logic [3:0] g, input logic [3:0] w);
    @(posedge wrclk);
    #2;
    g_rptr = g; b_wptr = w; wr_en = 1'b0; clr_err = 1'b0;
    wrst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("rst_async");
    repeat (2) @(posedge wrclk);
    #1;
    check_all_zero("rst_hold");
    wrst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] w;
    logic [3:0] lvl;
    logic       af;
    logic       full;
  } ramp_vec_t;

  ramp_vec_t ramp [9];

  logic [3:0] rb, wb, gin;
  logic       we_r, clr_r;

  initial begin
    // Expected values come from the rules: level = w - 0, almost_full when
    // the level is 6 or more, fifo_full when the level is 8.
    ramp[0] = '{4'd0, 4'd0, 1'b0, 1'b0};
    ramp[1] = '{4'd1, 4'd1, 1'b0, 1'b0};
    ramp[2] = '{4'd2, 4'd2, 1'b0, 1'b0};
    ramp[3] = '{4'd3, 4'd3, 1'b0, 1'b0};
    ramp[4] = '{4'd4, 4'd4, 1'b0, 1'b0};
    ramp[5] = '{4'd5, 4'd5, 1'b0, 1'b0};
    ramp[6] = '{4'd6, 4'd6, 1'b1, 1'b0};
    ramp[7] = '{4'd7, 4'd7, 1'b1, 1'b0};
    ramp[8] = '{4'd8, 4'd8, 1'b1, 1'b1};

    // Power-on reset with a nonzero g_rptr: outputs must stay at 0.
    model_reset();
    g_rptr = 4'b0101;
    @(posedge wrclk); #1;
    check_all_zero("por");
    @(posedge wrclk); #1;
    g_rptr = 4'b0000;
    wrst_n = 1'b1;

    // Reset release with all-zero inputs.
    cycle(4'd0, 4'd0, 1'b0, 1'b0);
    check_all_zero("rel");

    // g_rptr steps 0->1: g_rptr_sync follows 2 edges later and b_rptr_sync 3 edges later.
    cycle(4'd1, 4'd0, 1'b0, 1'b0);
    check("step_e1_gsync", 32'(g_rptr_sync), 0);
    cycle(4'd1, 4'd0, 1'b0, 1'b0);
    check("step_e2_gsync", 32'(g_rptr_sync), 1);
    check("step_e2_bsync", 32'(b_rptr_sync), 0);
    cycle(4'd1, 4'd0, 1'b0, 1'b0);
    check("step_e3_bsync", 32'(b_rptr_sync), 1);

    // Move the read pointer back to 0 so it settles for the ramp.
    repeat (4) cycle(4'd0, 4'd0, 1'b0, 1'b0);

    // Ramp the write pointer from 0 to 8 with the read pointer held at 0.
    for (int i = 0; i < 9; i++) begin
      cycle(4'd0, ramp[i].w, 1'b0, 1'b0);
      check($sformatf("ramp%0d_level", i), 32'(wr_level), 32'(ramp[i].lvl));
      check($sformatf("ramp%0d_afull", i), 32'(almost_full), 32'(ramp[i].af));
      check($sformatf("ramp%0d_full", i), 32'(fifo_full), 32'(ramp[i].full));
    end

    // Overflow: set, hold, clear, set and clear together, then a write while not full.
    cycle(4'd0, 4'd8, 1'b1, 1'b0);
    check("ovf_set", 32'(overflow_err), 1);
    cycle(4'd0, 4'd8, 1'b0, 1'b0);
    check("ovf_hold", 32'(overflow_err), 1);
    cycle(4'd0, 4'd8, 1'b0, 1'b1);
    check("ovf_clr", 32'(overflow_err), 0);
    cycle(4'd0, 4'd8, 1'b1, 1'b1);
    check("ovf_set_wins", 32'(overflow_err), 1);
    cycle(4'd0, 4'd7, 1'b0, 1'b1);
    check("ovf_clr2", 32'(overflow_err), 0);
    check("full_drop", 32'(fifo_full), 0);
    cycle(4'd0, 4'd7, 1'b1, 1'b0);
    check("ovf_not_full", 32'(overflow_err), 0);

    // Wrap case: walk the read pointer to binary 12 in Gray steps with
    // b_wptr = 2. The level is then (2 - 12) mod 16 = 6.
    for (int b = 1; b <= 12; b++) cycle(to_gray(4'(b)), 4'd2, 1'b0, 1'b0);
    repeat (4) cycle(4'b1010, 4'd2, 1'b0, 1'b0);
    check("wrap_bsync", 32'(b_rptr_sync), 12);
    check("wrap_level", 32'(wr_level), 6);
    check("wrap_afull", 32'(almost_full), 1);
    check("wrap_full", 32'(fifo_full), 0);

    // Gray checker: g_rptr jumps 0000 -> 0011.
    do_reset(4'd0, 4'd0);
    repeat (2) cycle(4'd0, 4'd0, 1'b0, 1'b0);
    repeat (4) cycle(4'b0011, 4'd0, 1'b0, 1'b0);
    check("gray_jump", 32'(gray_err), 32'(GRAY_ON));
    cycle(4'b0011, 4'd0, 1'b0, 1'b1);
    check("gray_clr", 32'(gray_err), 0);

    // Reset in mid-operation: after release, g_rptr needs the full
    // latency to reach the outputs.
    cycle(4'b0100, 4'd7, 1'b1, 1'b0);
    do_reset(4'b0100, 4'd7);
    cycle(4'b0100, 4'd7, 1'b0, 1'b0);
    check("rr_e1_gsync", 32'(g_rptr_sync), 0);
    check("rr_e1_bsync", 32'(b_rptr_sync), 0);
    cycle(4'b0100, 4'd7, 1'b0, 1'b0);
    check("rr_e2_gsync", 32'(g_rptr_sync), 4);
    check("rr_e2_bsync", 32'(b_rptr_sync), 0);
    cycle(4'b0100, 4'd7, 1'b0, 1'b0);
    check("rr_e3_bsync", 32'(b_rptr_sync), 7);
    check("rr_e3_level", 32'(wr_level), 7);
    check("rr_e3_afull", 32'(almost_full), 1);

    // Random traffic. The read pointer advances in Gray steps with occasional
    // illegal jumps. The write pointer random-walks, bounded by the depth.
    do_reset(4'd0, 4'd0);
    rb = '0;
    wb = '0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 1) == 1 && (wb - rb) < 4'd8) wb = wb + 4'd1;
      if ($urandom_range(0, 2) == 0 && rb != wb) rb = rb + 4'd1;
      gin   = ($urandom_range(0, 39) == 0) ? 4'($urandom) : to_gray(rb);
      we_r  = 1'($urandom);
      clr_r = ($urandom_range(0, 9) == 0);
      cycle(gin, wb, we_r, clr_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wr_rptr_sync_decoder.md
WR_RPTR_SYNC_DECODER -- requirements
Module: wr_rptr_sync_decoder

Interface
REQ-001 SHALL have parameter PTR_WIDTH, default 3, pointer address width; FIFO depth = 2**PTR_WIDTH.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flop count, legal range 2..4.
REQ-003 SHALL have parameter AFULL_THRESH, default 6, almost-full level, legal range 1..2**PTR_WIDTH.
REQ-004 SHALL have port wrclk, input, 1, write-domain clock.
REQ-005 SHALL have port wrst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port g_rptr, input, PTR_WIDTH+1, Gray read pointer from the read clock domain, asynchronous to wrclk.
REQ-007 SHALL have port b_wptr, input, PTR_WIDTH+1, binary write pointer, wrclk domain.
REQ-008 SHALL have port wr_en, input, 1, write attempt this cycle.
REQ-009 SHALL have port clr_err, input, 1, clears sticky error flags.
REQ-010 SHALL have port g_rptr_sync, output, PTR_WIDTH+1, synchronized Gray read pointer.
REQ-011 SHALL have port b_rptr_sync, output, PTR_WIDTH+1, decoded binary read pointer.
REQ-012 SHALL have port wr_level, output, PTR_WIDTH+1, FIFO occupancy seen from the write side.
REQ-013 SHALL have port fifo_full, output, 1; port almost_full, output, 1.
REQ-014 SHALL have port overflow_err, output, 1, sticky; port gray_err, output, 1, sticky.

Function
REQ-015 g_rptr SHALL pass through a SYNC_STAGES-deep flop chain; g_rptr_sync SHALL equal g_rptr sampled SYNC_STAGES wrclk edges earlier.
REQ-016 b_rptr_sync SHALL be the registered Gray-to-binary decode of g_rptr_sync, 1 cycle after g_rptr_sync (bit MSB copied; bit i = bit i+1 XOR g bit i).
REQ-017 wr_level SHALL be registered as (b_wptr - b_rptr_sync) modulo 2**(PTR_WIDTH+1), 1 cycle after its operands; pointer wrap-around is handled only by this modulo arithmetic, with no clamping.
REQ-018 fifo_full SHALL be registered high when the next wr_level equals 2**PTR_WIDTH, else low.
REQ-019 almost_full SHALL be registered high when the next wr_level >= AFULL_THRESH, else low.
REQ-020 overflow_err SHALL set on the edge after a cycle with wr_en=1 and fifo_full=1, hold until clr_err=1, and set SHALL win over a simultaneous clr_err.
REQ-021 gray_err (when compiled in) SHALL set when consecutive g_rptr_sync samples differ in more than one bit, hold until clr_err, and set SHALL win over a simultaneous clr_err.
REQ-022 Only the synchronizer input flop SHALL sample g_rptr; no other logic SHALL use unsynchronized g_rptr.

Reset
REQ-023 While wrst_n=0, all synchronizer flops and all outputs SHALL be 0 (fifo_full=0, almost_full=0, wr_level=0, errors=0).
REQ-024 Reset assertion mid-operation SHALL clear state immediately; after deassertion, outputs SHALL reflect g_rptr only after the full SYNC_STAGES+1 latency.

Configuration
REQ-025 With macro WR_GRAY_CHECK_EN defined, the Gray single-bit-change checker and gray_err SHALL be implemented per REQ-021.
REQ-026 Without WR_GRAY_CHECK_EN, gray_err SHALL be tied to 0 and no checker logic SHALL be present.

Structure
REQ-027 Shared package fifo_pkg SHALL hold the gray2bin and bin2gray functions and the default PTR_WIDTH constant.
REQ-028 The flop chain SHALL be sub-module sync_ff_chain (parameters WIDTH and STAGES, async active-low reset).

Verification
REQ-029 Reset release with g_rptr=4'b0000 and b_wptr=0 -> all outputs 0, with no errors.
REQ-030 Step g_rptr 0->1 (Gray) at cycle 0 -> g_rptr_sync=1 at cycle 2 and b_rptr_sync=1 at cycle 3.
REQ-031 Hold g_rptr=0 and ramp b_wptr 0..8 -> almost_full rises at wr_level=6 and fifo_full rises at wr_level=8.
REQ-032 Wrap case: b_wptr=4'b0010 and b_rptr_sync=4'b1100 -> wr_level=6 and almost_full=1.
REQ-033 fifo_full=1 with wr_en=1 for 1 cycle -> overflow_err=1 next cycle and stays 1; clr_err=1 -> overflow_err=0 next cycle; set and clear together -> overflow_err stays 1.
REQ-034 WR_GRAY_CHECK_EN defined, g_rptr jumps 0000->0011 -> gray_err=1 after propagation; macro undefined -> gray_err stays 0.
